// File: rtl/scoreboard_queue_if.sv
// Scoreboard queue shared types and handshake bundle.
// Entry/exception layouts live in the package; the interface groups ports.
package scoreboard_queue_pkg;
  typedef struct packed {
    logic [63:0] cause;
    logic [63:0] tval;
    logic        valid;
  } exception_t;

  typedef struct packed {
    logic [63:0] pc;
    logic [7:0]  op;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [63:0] result;
    logic        valid;
    exception_t  ex;
  } scoreboard_entry_t;
endpackage

interface scoreboard_queue_if #(
  parameter int NR_ENTRIES  = 8,
  parameter int NR_WB_PORTS = 2
);
  import scoreboard_queue_pkg::*;
  localparam int TRANS_ID_BITS = $clog2(NR_ENTRIES);

  logic                                      flush_i;
  scoreboard_entry_t                         decoded_instr_i;
  logic                                      decoded_instr_valid_i;
  logic                                      decoded_instr_ack_o;
  logic [TRANS_ID_BITS-1:0]                  issue_trans_id_o;
  logic [NR_WB_PORTS-1:0]                    wb_valid_i;
  logic [NR_WB_PORTS-1:0][TRANS_ID_BITS-1:0] wb_trans_id_i;
  logic [NR_WB_PORTS-1:0][63:0]              wb_data_i;
  exception_t [NR_WB_PORTS-1:0]              wb_ex_i;
  scoreboard_entry_t                         commit_instr_o;
  logic                                      commit_valid_o;
  logic                                      commit_ack_i;
  logic                                      full_o;
  logic                                      empty_o;
  logic [31:0]                               rd_busy_o;

  modport master (
    output flush_i, decoded_instr_i, decoded_instr_valid_i,
    output wb_valid_i, wb_trans_id_i, wb_data_i, wb_ex_i,
    output commit_ack_i,
    input  decoded_instr_ack_o, issue_trans_id_o,
    input  commit_instr_o, commit_valid_o,
    input  full_o, empty_o, rd_busy_o
  );

  modport slave (
    input  flush_i, decoded_instr_i, decoded_instr_valid_i,
    input  wb_valid_i, wb_trans_id_i, wb_data_i, wb_ex_i,
    input  commit_ack_i,
    output decoded_instr_ack_o, issue_trans_id_o,
    output commit_instr_o, commit_valid_o,
    output full_o, empty_o, rd_busy_o
  );
endinterface

// File: rtl/scoreboard_queue.sv
// In-order scoreboard: circular buffer, out-of-order writeback, in-order commit.
// Optional SB_WB_BYPASS_EN forwards a head writeback straight to commit.
module scoreboard_queue
  import scoreboard_queue_pkg::*;
#(
  parameter int NR_ENTRIES  = 8,
  parameter int NR_WB_PORTS = 2
) (
  input logic             clk_i,
  input logic             rst_ni,
  scoreboard_queue_if.slave sb
);
  localparam int TRANS_ID_BITS = $clog2(NR_ENTRIES);
  typedef logic [TRANS_ID_BITS-1:0] tag_t;
  typedef logic [TRANS_ID_BITS:0]   cnt_t;

  scoreboard_entry_t mem [NR_ENTRIES];
  logic [NR_ENTRIES-1:0] in_flight;
  tag_t head, tail;
  cnt_t cnt;

  logic [NR_ENTRIES-1:0]        wb_hit, wb_exh;
  logic [NR_ENTRIES-1:0][63:0]  wb_res;
  exception_t [NR_ENTRIES-1:0]  wb_exv;
  scoreboard_entry_t            new_e, ci;
  logic full, empty, cv, enq, deq;
  logic [31:0] busy;

  // Ascending port loop: the highest matching port overwrites earlier ones.
  always_comb begin
    wb_hit = '0;
    wb_exh = '0;
    wb_res = '0;
    wb_exv = '0;
    for (int i = 0; i < NR_ENTRIES; i++) begin
      for (int p = 0; p < NR_WB_PORTS; p++) begin
        if (sb.wb_valid_i[p] && in_flight[i] &&
            sb.wb_trans_id_i[p] == tag_t'(i)) begin
          wb_hit[i] = 1'b1;
          wb_res[i] = sb.wb_data_i[p];
          if (sb.wb_ex_i[p].valid) begin
            wb_exh[i] = 1'b1;
            wb_exv[i] = sb.wb_ex_i[p];
          end
        end
      end
    end
  end

  always_comb begin
    ci = mem[head];
`ifdef SB_WB_BYPASS_EN
    if (wb_hit[head]) begin
      ci.result = wb_res[head];
      ci.valid  = 1'b1;
      if (wb_exh[head]) ci.ex = wb_exv[head];
    end
    cv = in_flight[head] & (mem[head].valid | wb_hit[head]);
`else
    cv = in_flight[head] & mem[head].valid;
`endif
  end

  always_comb begin
    new_e        = sb.decoded_instr_i;
    new_e.valid  = 1'b0;
    new_e.result = '0;
    new_e.ex     = '0;
  end

  always_comb begin
    busy = '0;
    for (int i = 0; i < NR_ENTRIES; i++)
      if (in_flight[i]) busy[mem[i].rd] = 1'b1;
    busy[0] = 1'b0;
  end

  assign full  = (cnt == cnt_t'(NR_ENTRIES));
  assign empty = (cnt == '0);
  assign enq   = sb.decoded_instr_valid_i & ~full & ~sb.flush_i;
  assign deq   = sb.commit_ack_i & cv & ~sb.flush_i;

  assign sb.decoded_instr_ack_o = enq;
  assign sb.issue_trans_id_o    = tail;
  assign sb.commit_instr_o      = ci;
  assign sb.commit_valid_o      = cv;
  assign sb.full_o              = full;
  assign sb.empty_o             = empty;
  assign sb.rd_busy_o           = busy;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NR_ENTRIES; i++) mem[i] <= '0;
      in_flight <= '0;
      head      <= '0;
      tail      <= '0;
      cnt       <= '0;
    end else if (sb.flush_i) begin
      for (int i = 0; i < NR_ENTRIES; i++) mem[i].valid <= 1'b0;
      in_flight <= '0;
      head      <= '0;
      tail      <= '0;
      cnt       <= '0;
    end else begin
      for (int i = 0; i < NR_ENTRIES; i++) begin
        if (wb_hit[i]) begin
          mem[i].result <= wb_res[i];
          mem[i].valid  <= 1'b1;
          if (wb_exh[i]) mem[i].ex <= wb_exv[i];
        end
      end
      // Tail slot is never in flight unless full, so no clash with writeback.
      if (enq) begin
        mem[tail]       <= new_e;
        in_flight[tail] <= 1'b1;
        tail            <= tail + tag_t'(1);
      end
      if (deq) begin
        mem[head].valid <= 1'b0;
        in_flight[head] <= 1'b0;
        head            <= head + tag_t'(1);
      end
      cnt <= cnt + cnt_t'(enq) - cnt_t'(deq);
    end
  end
endmodule

// File: tb/tb_scoreboard_queue.sv
// Directed bench for scoreboard_queue with a queue-level reference model.
// Model and literal checks both follow SB_WB_BYPASS_EN when defined.
module tb_scoreboard_queue;
  import scoreboard_queue_pkg::*;

  localparam int N = 4;
  localparam int P = 2;

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  scoreboard_queue_if #(.NR_ENTRIES(N), .NR_WB_PORTS(P)) sbi ();

  scoreboard_queue #(.NR_ENTRIES(N), .NR_WB_PORTS(P)) u_dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .sb    (sbi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          tag;
    int          rd;
    logic [63:0] res;
    bit          done;
    bit          exv;
    logic [63:0] cause;
  } m_t;

  m_t mq[$];
  int next_tag = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Head state as seen by commit, including same-cycle forwarding if enabled.
  function automatic void m_head(output bit cv, output logic [63:0] res,
                                 output bit exv, output logic [63:0] cause,
                                 output int rd);
    cv = 0; res = '0; exv = 0; cause = '0; rd = 0;
    if (mq.size() > 0) begin
      cv = mq[0].done; res = mq[0].res;
      exv = mq[0].exv; cause = mq[0].cause; rd = mq[0].rd;
`ifdef SB_WB_BYPASS_EN
      for (int p = 0; p < P; p++)
        if (sbi.wb_valid_i[p] && int'(sbi.wb_trans_id_i[p]) == mq[0].tag) begin
          cv = 1; res = sbi.wb_data_i[p];
          if (sbi.wb_ex_i[p].valid) begin
            exv = 1; cause = sbi.wb_ex_i[p].cause;
          end
        end
`endif
    end
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      next_tag = 0;
    end else if (sbi.flush_i) begin
      mq.delete();
      next_tag = 0;
    end else begin
      bit cv, exv; logic [63:0] res, cause; int rd, n0;
      m_t e;
      n0 = mq.size();
      m_head(cv, res, exv, cause, rd);
      for (int p = 0; p < P; p++)
        if (sbi.wb_valid_i[p])
          foreach (mq[k])
            if (mq[k].tag == int'(sbi.wb_trans_id_i[p])) begin
              mq[k].res = sbi.wb_data_i[p];
              mq[k].done = 1;
              if (sbi.wb_ex_i[p].valid) begin
                mq[k].exv = 1; mq[k].cause = sbi.wb_ex_i[p].cause;
              end
            end
      if (sbi.commit_ack_i && cv) void'(mq.pop_front());
      if (sbi.decoded_instr_valid_i && n0 < N) begin
        e.tag = next_tag; e.rd = int'(sbi.decoded_instr_i.rd);
        e.res = '0; e.done = 0; e.exv = 0; e.cause = '0;
        mq.push_back(e);
        next_tag = (next_tag + 1) % N;
      end
    end
  end

  always @(negedge clk) begin
    bit cv, exv; logic [63:0] res, cause; int rd, n;
    logic [31:0] busy;
    n = mq.size();
    busy = '0;
    foreach (mq[k]) busy[mq[k].rd] = 1'b1;
    busy[0] = 1'b0;
    m_head(cv, res, exv, cause, rd);
    chk("m_full", sbi.full_o, 64'(n == N));
    chk("m_empty", sbi.empty_o, 64'(n == 0));
    chk("m_issue", sbi.issue_trans_id_o, 64'(next_tag));
    chk("m_busy", sbi.rd_busy_o, busy);
    chk("m_ack", sbi.decoded_instr_ack_o,
        64'(sbi.decoded_instr_valid_i && n < N && !sbi.flush_i));
    chk("m_cv", sbi.commit_valid_o, 64'(cv));
    if (cv) begin
      chk("m_res", sbi.commit_instr_o.result, res);
      chk("m_rd", sbi.commit_instr_o.rd, 64'(rd));
      chk("m_exv", sbi.commit_instr_o.ex.valid, 64'(exv));
      if (exv) chk("m_cause", sbi.commit_instr_o.ex.cause, cause);
    end
  end

  task automatic idle();
    sbi.flush_i = 0;
    sbi.decoded_instr_i = '0;
    sbi.decoded_instr_valid_i = 0;
    sbi.wb_valid_i = '0;
    sbi.wb_trans_id_i = '0;
    sbi.wb_data_i = '0;
    sbi.wb_ex_i = '0;
    sbi.commit_ack_i = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1 idle();
    #1;
  endtask

  task automatic enq(int rd);
    sbi.decoded_instr_valid_i = 1;
    sbi.decoded_instr_i.rd = 5'(rd);
    sbi.decoded_instr_i.pc = 64'(rd * 4);
  endtask

  task automatic wb(int p, int tag, logic [63:0] d, bit exv = 0,
                    logic [63:0] cause = '0);
    sbi.wb_valid_i[p] = 1;
    sbi.wb_trans_id_i[p] = 2'(tag);
    sbi.wb_data_i[p] = d;
    sbi.wb_ex_i[p].valid = exv;
    sbi.wb_ex_i[p].cause = cause;
  endtask

  initial begin
    rst_n = 0;
    idle();
    repeat (2) @(posedge clk);
    #2;
    chk("rst_empty", sbi.empty_o, 1);
    chk("rst_full", sbi.full_o, 0);
    chk("rst_cv", sbi.commit_valid_o, 0);
    chk("rst_busy", sbi.rd_busy_o, 0);
    chk("rst_instr", 64'(sbi.commit_instr_o == '0), 1);
    chk("rst_issue", sbi.issue_trans_id_o, 0);
    rst_n = 1;

    for (int i = 0; i < 4; i++) begin
      enq(i + 1);
      #1;
      chk("fill_ack", sbi.decoded_instr_ack_o, 1);
      chk("fill_tag", sbi.issue_trans_id_o, 64'(i));
      tick();
    end
    enq(5);
    #1;
    chk("fill5_ack", sbi.decoded_instr_ack_o, 0);
    chk("fill_full", sbi.full_o, 1);
    chk("fill_busy", sbi.rd_busy_o, 32'h1E);
    tick();

    wb(0, 2, 64'h22);
    tick();
    chk("ooo_blk", sbi.commit_valid_o, 0);
    wb(0, 0, 64'hAA);
    tick();
    chk("ooo_cv", sbi.commit_valid_o, 1);
    chk("ooo_res", sbi.commit_instr_o.result, 64'hAA);
    sbi.commit_ack_i = 1;
    tick();
    chk("t1_blk", sbi.commit_valid_o, 0);
    wb(0, 1, 64'h11);
    wb(1, 1, 64'h99);
    tick();
    chk("coll_res", sbi.commit_instr_o.result, 64'h99);
    sbi.commit_ack_i = 1;
    tick();
    chk("t2_res", sbi.commit_instr_o.result, 64'h22);
    sbi.commit_ack_i = 1;
    tick();
    wb(1, 3, 64'h33, 1, 64'd5);
    tick();
    chk("ex_v", sbi.commit_instr_o.ex.valid, 1);
    chk("ex_cause", sbi.commit_instr_o.ex.cause, 64'd5);
    sbi.commit_ack_i = 1;
    tick();
    chk("drain_empty", sbi.empty_o, 1);

    for (int k = 0; k < 6; k++) begin
      enq(k + 8);
      #1 chk("wrap_tag", sbi.issue_trans_id_o, 64'(k % 4));
      tick();
      wb(0, k % 4, 64'(k + 100));
      tick();
      sbi.commit_ack_i = 1;
      tick();
    end
    chk("wrap_empty", sbi.empty_o, 1);

    for (int k = 0; k < 3; k++) begin
      enq(k + 10);
      tick();
    end
    sbi.flush_i = 1;
    enq(20);
    wb(0, 2, 64'h77);
    #1 chk("flush_ack", sbi.decoded_instr_ack_o, 0);
    tick();
    chk("flush_empty", sbi.empty_o, 1);
    chk("flush_busy", sbi.rd_busy_o, 0);
    chk("flush_tag", sbi.issue_trans_id_o, 0);

    enq(13);
    tick();
    wb(0, 0, 64'h55);
    sbi.commit_ack_i = 1;
`ifdef SB_WB_BYPASS_EN
    #1 chk("byp_cv", sbi.commit_valid_o, 1);
    chk("byp_res", sbi.commit_instr_o.result, 64'h55);
    tick();
    chk("byp_empty", sbi.empty_o, 1);
`else
    #1 chk("nbyp_cv", sbi.commit_valid_o, 0);
    tick();
    chk("nbyp_empty", sbi.empty_o, 0);
    chk("nbyp_res", sbi.commit_instr_o.result, 64'h55);
    sbi.commit_ack_i = 1;
    tick();
    chk("nbyp_done", sbi.empty_o, 1);
`endif

    enq(14);
    tick();
    chk("mid_busy", sbi.rd_busy_o, 32'h4000);
    rst_n = 0;
    #1;
    chk("mid_empty", sbi.empty_o, 1);
    chk("mid_rbusy", sbi.rd_busy_o, 0);
    tick();
    rst_n = 1;

    for (int i = 0; i < 4; i++) begin
      enq(i + 1);
      tick();
    end
    wb(0, 0, 64'h1);
    tick();
    enq(5);
    sbi.commit_ack_i = 1;
    #1 chk("fullc_ack", sbi.decoded_instr_ack_o, 0);
    tick();
    chk("fullc_full", sbi.full_o, 0);
    wb(0, 1, 64'h2);
    tick();
    enq(5);
    sbi.commit_ack_i = 1;
    #1 chk("pair_ack", sbi.decoded_instr_ack_o, 1);
    chk("pair_tag", sbi.issue_trans_id_o, 0);
    tick();
    chk("pair_full", sbi.full_o, 0);
    chk("pair_busy", sbi.rd_busy_o, 32'h38);

    sbi.flush_i = 1;
    tick();
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
